gpu_frame_capture: RTL and testbench

Single-clock video capture engine that watches a VGA-style stream (de/hsync/vsync/9-bit pixel) and writes the frame back into memory as a bus initiator. Each pixel is reduced to 1 bit, 32 pixels are packed LSB-first into a word, and words are written to consecutive word addresses starting at BASE_ADDR. It is used for loopback self-test of the display path and for screen grabs into the framebuffer address space.

---
 rtl/gpu_capture_pkg.sv | 22 ++
 rtl/capture_fifo.sv | 67 ++++++
 rtl/gpu_frame_capture.sv | 207 ++++++++++++++++++++
 tb/tb_gpu_frame_capture.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_capture_pkg.sv
// Shared definitions for the frame capture engine: FSM encoding, FIFO entry
// layout and the words-per-frame helper.
package gpu_capture_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_WAIT_VS = 2'd1;
    localparam state_t ST_CAPTURE = 2'd2;
    localparam state_t ST_DRAIN   = 2'd3;

    localparam int unsigned IDX_W   = 24;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ENTRY_W = IDX_W + DATA_W;

    // One packed word holds 32 one-bit pixels.
    function automatic int unsigned capture_words(input int unsigned hor,
                                                  input int unsigned ver);
        return (hor * ver) / 32;
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous FIFO of {word_idx, data} entries. Exposes the head entry and
// the one behind it so the bus register can reload in the cycle of a pop.
module capture_fifo #(
    parameter int unsigned WIDTH = 56,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_bus,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [WIDTH-1:0]         next_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;
    logic [PW-1:0]    w_rd_next;

    assign full      = (r_count == (PW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_do_pop  = pop & ~empty;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign w_do_push = push & (~full | w_do_pop);
    assign w_rd_next = r_rd_ptr + PW'(1);
    assign head_data = r_mem[r_rd_ptr];
    assign next_data = r_mem[w_rd_next];

    // Storage array; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clk_bus) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_bus) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/gpu_frame_capture.sv
// Video frame capture engine: reduces each active pixel to one bit, packs 32
// pixels LSB-first per word and writes the words to consecutive addresses.
//
// state      | meaning
// IDLE       | capture disarmed, bus idle
// WAIT_VS    | armed, waiting for the vsync rising edge that starts a frame
// CAPTURE    | packing active pixels and queueing words
// DRAIN      | frame closed, flushing queued words before frame_done
module gpu_frame_capture
    import gpu_capture_pkg::*;
#(
    parameter int unsigned HOR_PXL    = 800,
    parameter int unsigned VER_PXL    = 600,
    parameter logic [23:0] BASE_ADDR  = 24'h000000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_bus,
    input  logic        rst_n,
    input  logic        de,
    input  logic        vsync,
    input  logic        hsync,
    input  logic [8:0]  pxlData,
    input  logic        enable,
    output logic [23:0] bus_address,
    output logic [31:0] bus_data_o,
    output logic        bus_write,
    output logic        bus_read,
    input  logic        bus_stall,
    output logic        busy,
    output logic        frame_done,
    output logic        capture_err
);

    localparam int unsigned WORDS    = capture_words(HOR_PXL, VER_PXL);
    localparam logic [23:0] LAST_IDX = 24'(WORDS - 1);
    localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;

    logic               r_de_q;
    logic               r_vsync_q;
    logic               r_vsync_qq;
    logic [8:0]         r_pxl_q;
    state_t             r_state;
    logic [4:0]         r_bit_cnt;
    logic [31:0]        r_shift;
    logic [23:0]        r_word_idx;
    logic               r_capture_err;
    logic               r_frame_done;
    logic               r_bus_write;
    logic [23:0]        r_bus_address;
    logic [31:0]        r_bus_data;

    logic               w_vs_rise;
    logic               w_pixel_bit;
    logic [31:0]        w_packed;
    logic               w_word_done;
    logic               w_push;
    logic               w_pop;
    logic               w_overflow;
    logic               w_drain_done;
    logic [ENTRY_W-1:0] w_push_entry;
    logic [ENTRY_W-1:0] w_head;
    logic [ENTRY_W-1:0] w_next;
    logic [CW-1:0]      w_count;
    logic               w_full;
    logic               w_empty;
    logic               w_unused;

    assign w_vs_rise    = r_vsync_q & ~r_vsync_qq;
    assign w_pixel_bit  = |r_pxl_q;
    assign w_packed     = {w_pixel_bit, r_shift[31:1]};
    assign w_word_done  = (r_state == ST_CAPTURE) & ~w_vs_rise & r_de_q
                          & (r_bit_cnt == 5'd31);
    // The word on the bus is the FIFO head; it leaves only when accepted.
    assign w_pop        = r_bus_write & ~bus_stall;
    assign w_push       = w_word_done & (~w_full | w_pop);
    assign w_overflow   = w_word_done & w_full & ~w_pop;
    assign w_push_entry = {r_word_idx, w_packed};
    assign w_drain_done = (r_state == ST_DRAIN)
                          & (w_empty | (w_pop & (w_count == CW'(1))));

    assign bus_address  = r_bus_address;
    assign bus_data_o   = r_bus_data;
    assign bus_write    = r_bus_write;
    assign bus_read     = 1'b0;
    assign busy         = (r_state != ST_IDLE);
    assign frame_done   = r_frame_done;
    assign capture_err  = r_capture_err;
    // hsync is observed only; the top index bits never reach the address.
    assign w_unused     = ^{hsync, w_head[ENTRY_W-1:54], w_next[ENTRY_W-1:54]};

    capture_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_bus   (clk_bus),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head_data (w_head),
        .next_data (w_next),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Input stage: one register on every video input, plus vsync history.
    always_ff @(posedge clk_bus) begin
        if (!rst_n) begin
            r_de_q     <= 1'b0;
            r_vsync_q  <= 1'b0;
            r_vsync_qq <= 1'b0;
            r_pxl_q    <= '0;
        end else begin
            r_de_q     <= de;
            r_vsync_q  <= vsync;
            r_vsync_qq <= r_vsync_q;
            r_pxl_q    <= pxlData;
        end
    end

    // Frame sequencing and pixel packing.
    always_ff @(posedge clk_bus) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_word_idx    <= '0;
            r_capture_err <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state <= ST_WAIT_VS;
                    end
                end
                ST_WAIT_VS: begin
                    if (w_vs_rise) begin
                        r_state       <= ST_CAPTURE;
                        r_bit_cnt     <= '0;
                        r_word_idx    <= '0;
                        r_capture_err <= 1'b0;
                    end else if (!enable) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CAPTURE: begin
                    if (w_vs_rise) begin
                        // Short frame: the partial word is simply abandoned.
                        r_state       <= ST_DRAIN;
                        r_bit_cnt     <= '0;
                        r_capture_err <= 1'b1;
                    end else if (r_de_q) begin
                        r_shift <= w_packed;
                        if (r_bit_cnt == 5'd31) begin
                            r_bit_cnt  <= '0;
                            // Dropped words still advance the index so the
                            // surviving words keep their true addresses.
                            r_word_idx <= r_word_idx + 24'd1;
                            if (w_overflow) begin
                                r_capture_err <= 1'b1;
                            end
                            if (r_word_idx == LAST_IDX) begin
                                r_state <= ST_DRAIN;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_drain_done) begin
                        r_frame_done <= 1'b1;
                        r_state      <= enable ? ST_WAIT_VS : ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Bus output register: loads the FIFO head, holds while stalled, and
    // reloads with the following entry in the cycle a write is accepted.
    always_ff @(posedge clk_bus) begin
        if (!rst_n) begin
            r_bus_write   <= 1'b0;
            r_bus_address <= '0;
            r_bus_data    <= '0;
        end else if (!r_bus_write) begin
            if (!w_empty) begin
                r_bus_write   <= 1'b1;
                r_bus_address <= BASE_ADDR + {w_head[53:32], 2'b00};
                r_bus_data    <= w_head[31:0];
            end
        end else if (!bus_stall) begin
            if (w_count > CW'(1)) begin
                r_bus_address <= BASE_ADDR + {w_next[53:32], 2'b00};
                r_bus_data    <= w_next[31:0];
            end else begin
                r_bus_write <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gpu_frame_capture.sv
// Self-checking bench for gpu_frame_capture on a 64x2 frame, FIFO depth 2,
// base address near the top of the 24-bit space so addresses wrap.
module tb_gpu_frame_capture;

    localparam int          HOR   = 64;
    localparam int          VER   = 2;
    localparam int          DEPTH = 2;
    localparam logic [23:0] BASE  = 24'hFFFFF8;

    logic        clk_bus;
    logic        rst_n;
    logic        de;
    logic        vsync;
    logic        hsync;
    logic [8:0]  pxlData;
    logic        enable;
    logic [23:0] bus_address;
    logic [31:0] bus_data_o;
    logic        bus_write;
    logic        bus_read;
    logic        bus_stall;
    logic        busy;
    logic        frame_done;
    logic        capture_err;

    gpu_frame_capture #(
        .HOR_PXL    (HOR),
        .VER_PXL    (VER),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_bus     (clk_bus),
        .rst_n       (rst_n),
        .de          (de),
        .vsync       (vsync),
        .hsync       (hsync),
        .pxlData     (pxlData),
        .enable      (enable),
        .bus_address (bus_address),
        .bus_data_o  (bus_data_o),
        .bus_write   (bus_write),
        .bus_read    (bus_read),
        .bus_stall   (bus_stall),
        .busy        (busy),
        .frame_done  (frame_done),
        .capture_err (capture_err)
    );

    initial clk_bus = 1'b0;
    always #5 clk_bus = ~clk_bus;

    int cyc = 0;
    always @(posedge clk_bus) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int npx;
        int pat;
        int st_off;
        int st_len;
        int keep;
        bit exp_err;
        bit aborted;
    } vec_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  st_from = 0;
    int  st_to = 0;
    int  done_cnt = 0;
    int  held_cnt = 0;
    int  last_acc_cyc = -100;
    int  px31_cyc = 0;
    int  first_wr_cyc = 0;
    bit  lat_armed = 0;
    bit  done_timing_en = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] pix(input int pat, input int k);
        logic [8:0] v;
        v = 9'h000;
        case (pat)
            0: v = (k % 2 == 0) ? 9'h1FF : 9'h000;
            1: case (k % 5)
                   1: v = 9'h001;
                   2: v = 9'h100;
                   4: v = 9'h010;
                   default: v = 9'h000;
               endcase
            default: v = (((k * k) + (k / 3)) % 3 == 0) ? 9'h080 : 9'h000;
        endcase
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_bus);
        #1;
        bus_stall = (cyc >= st_from) && (cyc < st_to);
    endtask

    // Drives one frame and pushes the bench's expected words to the scoreboard.
    task automatic drive_frame(input int npx, input int pat, input int keep, input int drop_at);
        logic [31:0] w;
        w = '0;
        vsync = 1'b1;
        tick();
        tick();
        vsync = 1'b0;
        repeat (4) tick();
        for (int k = 0; k < npx; k++) begin
            if (k > 0 && k % HOR == 0) begin
                de = 1'b0;
                pxlData = '0;
                hsync = 1'b1;
                tick();
                tick();
                hsync = 1'b0;
                repeat (6) tick();
            end
            de = 1'b1;
            pxlData = pix(pat, k);
            if (k == drop_at) enable = 1'b0;
            if (k == 31) px31_cyc = cyc;
            w[k % 32] = (pix(pat, k) != 9'h000);
            if (k % 32 == 31 && (k / 32) < keep) begin
                exp_q.push_back('{addr: BASE + 24'(4 * (k / 32)), data: w});
            end
            tick();
        end
        de = 1'b0;
        pxlData = '0;
        tick();
    endtask

    task automatic wait_done(input int base, input int maxc);
        for (int t = 0; t < maxc && done_cnt == base; t++) tick();
        repeat (4) tick();
        chk("frame_done_count", done_cnt - base, 1);
    endtask

    // Bus monitor: scoreboard compare on accept, hold-stable and pulse checks.
    logic        prev_wr = 0, prev_stall = 0, prev_done = 0, prev_rst = 0;
    logic [23:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    always @(negedge clk_bus) begin
        wr_t e;
        if (rst_n && bus_write && !bus_stall) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h, none expected", bus_address, bus_data_o);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", bus_address, e.addr);
                chk("wr_data", bus_data_o, e.data);
            end
            last_acc_cyc = cyc;
        end
        if (rst_n && prev_rst && prev_wr && prev_stall) begin
            chk("held_write", bus_write, 1'b1);
            chk("held_addr", bus_address, prev_addr);
            chk("held_data", bus_data_o, prev_data);
        end
        if (bus_write && bus_stall) held_cnt++;
        if (lat_armed && bus_write) begin
            first_wr_cyc = cyc;
            lat_armed = 0;
        end
        if (frame_done) begin
            done_cnt++;
            if (done_timing_en) chk("done_after_accept", cyc - last_acc_cyc, 1);
        end
        if (prev_done) chk("done_one_cycle", frame_done, 1'b0);
        prev_wr = bus_write;
        prev_stall = bus_stall;
        prev_done = frame_done;
        prev_rst = rst_n;
        prev_addr = bus_address;
        prev_data = bus_data_o;
    end

    vec_t vecs[6];

    initial begin
        int base;
        vecs[0] = '{npx: 128, pat: 0, st_off: 0,  st_len: 0,   keep: 4, exp_err: 0, aborted: 0};
        vecs[1] = '{npx: 128, pat: 0, st_off: 60, st_len: 20,  keep: 4, exp_err: 0, aborted: 0};
        vecs[2] = '{npx: 128, pat: 1, st_off: 0,  st_len: 0,   keep: 4, exp_err: 0, aborted: 0};
        vecs[3] = '{npx: 128, pat: 2, st_off: 0,  st_len: 150, keep: 2, exp_err: 1, aborted: 0};
        vecs[4] = '{npx: 70,  pat: 1, st_off: 0,  st_len: 0,   keep: 2, exp_err: 1, aborted: 1};
        vecs[5] = '{npx: 128, pat: 2, st_off: 0,  st_len: 0,   keep: 4, exp_err: 0, aborted: 0};

        rst_n = 1'b0;
        enable = 1'b0;
        de = 1'b0;
        vsync = 1'b0;
        hsync = 1'b0;
        pxlData = '0;
        bus_stall = 1'b0;
        repeat (3) tick();
        @(negedge clk_bus);
        chk("rst_bus_address", bus_address, 24'h0);
        chk("rst_bus_data", bus_data_o, 32'h0);
        chk("rst_bus_write", bus_write, 1'b0);
        chk("rst_bus_read", bus_read, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_capture_err", capture_err, 1'b0);
        tick();
        rst_n = 1'b1;
        enable = 1'b1;
        repeat (3) tick();
        chk("armed_busy", busy, 1'b1);

        for (int i = 0; i < 6; i++) begin
            held_cnt = 0;
            base = done_cnt;
            done_timing_en = !vecs[i].aborted;
            if (vecs[i].st_len > 0) begin
                st_from = cyc + 6 + vecs[i].st_off;
                st_to = st_from + vecs[i].st_len;
            end else begin
                st_from = 0;
                st_to = 0;
            end
            lat_armed = (i == 0);
            drive_frame(vecs[i].npx, vecs[i].pat, vecs[i].keep, -1);
            if (vecs[i].aborted) begin
                repeat (3) tick();
                vsync = 1'b1;
                tick();
                tick();
                vsync = 1'b0;
            end
            wait_done(base, 400);
            if (i == 0) chk("first_write_latency", first_wr_cyc - px31_cyc, 3);
            chk("capture_err", capture_err, vecs[i].exp_err);
            chk("busy_rearmed", busy, 1'b1);
            chk("queue_drained", exp_q.size(), 0);
            if (vecs[i].st_len > 0) chk("stall_seen", held_cnt > 0, 1'b1);
        end

        // enable dropped mid-frame: the frame finishes, then the engine idles
        done_timing_en = 1;
        base = done_cnt;
        drive_frame(128, 1, 4, 40);
        wait_done(base, 400);
        chk("disarm_busy", busy, 1'b0);
        chk("disarm_err", capture_err, 1'b0);
        chk("disarm_queue", exp_q.size(), 0);
        base = done_cnt;
        drive_frame(128, 0, 0, -1);
        repeat (10) tick();
        chk("ignored_busy", busy, 1'b0);
        chk("ignored_done", done_cnt - base, 0);

        // reset while a write is pending and stalled
        enable = 1'b1;
        repeat (3) tick();
        st_from = cyc;
        st_to = cyc + 100000;
        drive_frame(40, 0, 0, -1);
        for (int t = 0; t < 50 && !bus_write; t++) tick();
        chk("pre_reset_write", bus_write, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk_bus);
        chk("reset_bus_write", bus_write, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_addr", bus_address, 24'h0);
        chk("reset_data", bus_data_o, 32'h0);
        chk("reset_done", frame_done, 1'b0);
        st_from = 0;
        st_to = 0;
        tick();
        repeat (3) tick();
        base = done_cnt;
        drive_frame(128, 2, 4, -1);
        wait_done(base, 400);
        chk("post_reset_err", capture_err, 1'b0);
        chk("post_reset_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
